riscv_test_monitor: RTL and testbench
=====================================

RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 10000, giving the run-cycle limit before timeout.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, giving the pipeline-drain wait between halt detection and the a0 sample.
REQ-003 SHALL have parameter HALT_INST, default 32'hdead10cc, the halt instruction word.
REQ-004 SHALL have parameter PASS_MAGIC, default 32'h00c0ffee, the a0 value meaning pass.
REQ-005 SHALL have parameter FAIL_MAGIC, default 32'hdeaddead, the a0 value meaning fail.
REQ-006 SHALL have port i_Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_start, input, 1 bit: single-cycle pulse that arms a new test run.
REQ-009 SHALL have port i_inst_data, input, 32 bits: instruction word currently in the IF/ID stage.
REQ-010 SHALL have port i_a0, input, 32 bits: live value of register x10.
REQ-011 SHALL have port o_busy, output, 1 bit: high in RUN or DRAIN.
REQ-012 SHALL have port o_done, output, 1 bit: high in DONE.
REQ-013 SHALL have port o_status, output, 2 bits: 00 pending, 01 pass, 10 fail, 11 unknown or timeout.
REQ-014 SHALL have port o_timeout, output, 1 bit: high when the run ended by the cycle limit.
REQ-015 SHALL have port o_cycles, output, 32 bits: count of RUN cycles up to and including the halt cycle.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL go from IDLE to RUN on i_start, clearing o_cycles, o_status and o_timeout in that same edge.
REQ-018 SHALL, in RUN, add 1 to o_cycles on every cycle in which i_inst_data != HALT_INST.
REQ-019 SHALL, in RUN with i_inst_data == HALT_INST, add 1 to o_cycles for the halt cycle, freeze the counter, load a drain counter with DRAIN_CYCLES and go to DRAIN.
REQ-020 SHALL, in RUN when the pre-increment count equals MAX_CYCLES and no halt is present, go to DONE with o_timeout=1, o_status=11 and o_cycles=MAX_CYCLES.
REQ-021 SHALL give halt priority over timeout when both occur in the same cycle.
REQ-022 SHALL, in DRAIN, decrement the drain counter each cycle; on the cycle it reads 0, sample i_a0 and go to DONE.
REQ-023 SHALL set o_status to 01 if the sampled i_a0 == PASS_MAGIC, 10 if it == FAIL_MAGIC, and 11 otherwise.
REQ-024 SHALL, with DRAIN_CYCLES=0, sample i_a0 on the first DRAIN cycle (total latency halt-to-DONE = DRAIN_CYCLES+1 edges).
REQ-025 SHALL hold o_status, o_timeout and o_cycles stable in DONE until the next i_start.
REQ-026 SHALL restart a run from RUN, DRAIN or DONE on i_start exactly as from IDLE; i_start takes priority over every other transition.
REQ-027 SHALL ignore i_inst_data and i_a0 in IDLE and DONE.
REQ-028 SHALL saturate o_cycles at 32'hffffffff and never wrap, even when MAX_CYCLES exceeds that range.
REQ-029 SHALL drive o_busy and o_done combinationally from the state, with no extra latency.

Reset
REQ-030 SHALL, while i_reset_n=0, immediately force state IDLE, o_cycles=0, o_status=00, o_timeout=0, drain counter=0, o_busy=0 and o_done=0.
REQ-031 SHALL discard a run in progress when reset asserts mid-run; the run does not resume after reset releases.
REQ-032 SHALL, after reset releases, remain in IDLE until the first rising edge at which i_start=1.

Structure
REQ-033 SHALL place the state enum, the 2-bit status encoding and the default HALT/PASS/FAIL constants in shared package riscv_test_pkg.
REQ-034 SHALL be a single module with no sub-modules; the saturating counter and the drain counter are inline.

Verification
REQ-035 SHALL cover pass: start, 20 non-halt words, then dead10cc, with a0=00c0ffee -> done after 5 more edges, status=01, cycles=21, timeout=0.
REQ-036 SHALL cover fail: same sequence with a0=deaddead -> status=10; with a0=00000000 -> status=11.
REQ-037 SHALL cover timeout: MAX_CYCLES=50 with no halt -> done at cycle 50, timeout=1, status=11, cycles=50; with halt exactly on cycle 51 -> halt wins, status from a0.
REQ-038 SHALL cover late a0: a0 changes to 00c0ffee 3 edges after the halt with DRAIN_CYCLES=4 -> status=01.
REQ-039 SHALL cover reset mid-run: i_reset_n low in DRAIN -> all outputs 0 asynchronously, IDLE held afterwards, a subsequent start gives a correct fresh result.
REQ-040 SHALL cover back-to-back runs: i_start pulsed in DONE and again mid-RUN -> counter cleared each time, and only the last run's result is reported.

Source files
------------

// File: rtl/riscv_test_pkg.sv
// Shared types and default constants for the RISC-V test-completion monitor.
package riscv_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STATUS_PENDING = 2'b00,
        STATUS_PASS    = 2'b01,
        STATUS_FAIL    = 2'b10,
        STATUS_UNKNOWN = 2'b11
    } status_t;

    localparam logic [31:0] DEFAULT_HALT_INST  = 32'hdead10cc;
    localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'h00c0ffee;
    localparam logic [31:0] DEFAULT_FAIL_MAGIC = 32'hdeaddead;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hffffffff) ? value : value + 32'd1;
    endfunction

    function automatic status_t classify(input logic [31:0] a0,
                                         input logic [31:0] pass_magic,
                                         input logic [31:0] fail_magic);
        if (a0 == pass_magic) return STATUS_PASS;
        if (a0 == fail_magic) return STATUS_FAIL;
        return STATUS_UNKNOWN;
    endfunction

endpackage

// File: rtl/riscv_test_monitor.sv
// Watches a core for the halt word, waits for the pipeline to drain, then
// classifies the test result from a0; a cycle limit catches runaway tests.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter logic [63:0] MAX_CYCLES   = 64'd10000,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INST    = DEFAULT_HALT_INST,
    parameter logic [31:0] PASS_MAGIC   = DEFAULT_PASS_MAGIC,
    parameter logic [31:0] FAIL_MAGIC   = DEFAULT_FAIL_MAGIC
) (
    input  logic        i_Clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [31:0] i_inst_data,
    input  logic [31:0] i_a0,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_status,
    output logic        o_timeout,
    output logic [31:0] o_cycles
);

    state_t      state_q, state_d;
    status_t     status_q, status_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] drain_q, drain_d;

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            status_q  <= STATUS_PENDING;
            timeout_q <= 1'b0;
            cycles_q  <= 32'd0;
            drain_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
            drain_q   <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        drain_d   = drain_q;
        // A start pulse re-arms from any state, including mid-run.
        if (i_start) begin
            state_d   = ST_RUN;
            status_d  = STATUS_PENDING;
            timeout_d = 1'b0;
            cycles_d  = 32'd0;
            drain_d   = 32'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_inst_data == HALT_INST) begin
                        cycles_d = sat_inc(cycles_q);
                        drain_d  = DRAIN_CYCLES;
                        state_d  = ST_DRAIN;
                    end else if ({32'd0, cycles_q} == MAX_CYCLES) begin
                        timeout_d = 1'b1;
                        status_d  = STATUS_UNKNOWN;
                        state_d   = ST_DONE;
                    end else begin
                        cycles_d = sat_inc(cycles_q);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 32'd0) begin
                        status_d = classify(i_a0, PASS_MAGIC, FAIL_MAGIC);
                        state_d  = ST_DONE;
                    end else begin
                        drain_d = drain_q - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done    = (state_q == ST_DONE);
    assign o_status  = status_q;
    assign o_timeout = timeout_q;
    assign o_cycles  = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: instance 0 uses defaults, instance 1 uses a
// 50-cycle limit with no drain wait.
module tb_riscv_test_monitor;

    localparam logic [31:0] HALT    = 32'hdead10cc;
    localparam logic [31:0] PASS_V  = 32'h00c0ffee;
    localparam logic [31:0] FAIL_V  = 32'hdeaddead;
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam int          DRAIN_A = 4;
    localparam int          DRAIN_B = 0;

    typedef struct packed {
        logic [1:0]  status;
        logic        timeout;
        logic [31:0] cycles;
        logic [31:0] done_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_s   [2];
    logic [31:0] inst_s    [2];
    logic [31:0] a0_s      [2];
    logic        busy_s    [2];
    logic        done_s    [2];
    logic [1:0]  status_s  [2];
    logic        timeout_s [2];
    logic [31:0] cycles_s  [2];

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    exp_t        held  [2];
    logic        held_valid[2];
    logic        done_q[2];
    exp_t        mon_e;
    int          run_cnt[2];
    logic [31:0] cyc = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    riscv_test_monitor dut_a (
        .i_Clk(clk), .i_reset_n(rst_n), .i_start(start_s[0]),
        .i_inst_data(inst_s[0]), .i_a0(a0_s[0]),
        .o_busy(busy_s[0]), .o_done(done_s[0]), .o_status(status_s[0]),
        .o_timeout(timeout_s[0]), .o_cycles(cycles_s[0])
    );

    riscv_test_monitor #(.MAX_CYCLES(64'd50), .DRAIN_CYCLES(DRAIN_B)) dut_b (
        .i_Clk(clk), .i_reset_n(rst_n), .i_start(start_s[1]),
        .i_inst_data(inst_s[1]), .i_a0(a0_s[1]),
        .o_busy(busy_s[1]), .o_done(done_s[1]), .o_status(status_s[1]),
        .o_timeout(timeout_s[1]), .o_cycles(cycles_s[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_idle(input int id, input string tag);
        check({tag, "_busy"},    32'(busy_s[id]),    32'd0);
        check({tag, "_done"},    32'(done_s[id]),    32'd0);
        check({tag, "_status"},  32'(status_s[id]),  32'd0);
        check({tag, "_timeout"}, 32'(timeout_s[id]), 32'd0);
        check({tag, "_cycles"},  cycles_s[id],       32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int id);
        start_s[id] = 1'b1;
        @(posedge clk);
        #1;
        start_s[id] = 1'b0;
        run_cnt[id] = 0;
        check("start_busy",    32'(busy_s[id]),    32'd1);
        check("start_done",    32'(done_s[id]),    32'd0);
        check("start_status",  32'(status_s[id]),  32'd0);
        check("start_timeout", 32'(timeout_s[id]), 32'd0);
        check("start_cycles",  cycles_s[id],       32'd0);
    endtask

    task automatic words(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            inst_s[id] = NOP + 32'(i * 128);
            @(posedge clk);
            #1;
            run_cnt[id]++;
        end
    endtask

    task automatic halt(input int id, input logic [31:0] a0v, input logic [1:0] st);
        exp_t e;
        inst_s[id] = HALT;
        a0_s[id]   = a0v;
        @(posedge clk);
        #1;
        run_cnt[id]++;
        e = '{status: st, timeout: 1'b0, cycles: 32'(run_cnt[id]),
              done_cyc: cyc + 32'((id == 0 ? DRAIN_A : DRAIN_B) + 1)};
        if (id == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        inst_s[id] = NOP;
    endtask

    // Scoreboard monitor: pops on each rising done, then checks the result holds.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            if (done_s[id] && !done_q[id]) begin
                if ((id == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    check("unexpected_done", 32'(done_s[id]), 32'd0);
                    held_valid[id] = 1'b0;
                end else begin
                    if (id == 0) mon_e = exp_q0.pop_front();
                    else mon_e = exp_q1.pop_front();
                    held[id] = mon_e;
                    held_valid[id] = 1'b1;
                    check("done_status",  32'(status_s[id]),  32'(mon_e.status));
                    check("done_timeout", 32'(timeout_s[id]), 32'(mon_e.timeout));
                    check("done_cycles",  cycles_s[id],       mon_e.cycles);
                    check("done_latency", cyc,                mon_e.done_cyc);
                end
            end else if (done_s[id] && held_valid[id]) begin
                check("hold_status",  32'(status_s[id]),  32'(held[id].status));
                check("hold_timeout", 32'(timeout_s[id]), 32'(held[id].timeout));
                check("hold_cycles",  cycles_s[id],       held[id].cycles);
            end
            done_q[id] = done_s[id];
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        for (int id = 0; id < 2; id++) begin
            start_s[id] = 1'b0;
            inst_s[id]  = NOP;
            a0_s[id]    = 32'd0;
            done_q[id]  = 1'b0;
            held_valid[id] = 1'b0;
            run_cnt[id] = 0;
        end
        #2;
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        check_idle(0, "post_reset_a");

        // Pass, then junk on the inputs while DONE must be ignored.
        pulse_start(0); words(0, 20); halt(0, PASS_V, 2'b01); idle(7);
        inst_s[0] = HALT; a0_s[0] = FAIL_V; idle(4); inst_s[0] = NOP;

        // Fail and unknown a0 values.
        pulse_start(0); words(0, 20); halt(0, FAIL_V, 2'b10); idle(8);
        pulse_start(0); words(0, 20); halt(0, 32'd0, 2'b11); idle(8);

        // a0 settles only 3 edges after the halt edge.
        pulse_start(0); words(0, 6); halt(0, 32'd0, 2'b01); idle(3);
        a0_s[0] = PASS_V; idle(6);

        // Timeout at the 50-cycle limit with no halt.
        pulse_start(1); words(1, 50);
        check("limit_still_busy", 32'(busy_s[1]), 32'd1);
        check("limit_cycles", cycles_s[1], 32'd50);
        @(posedge clk);
        #1;
        e = '{status: 2'b11, timeout: 1'b1, cycles: 32'd50, done_cyc: cyc};
        exp_q1.push_back(e);
        idle(3);

        // Halt arriving exactly on the limit cycle wins over timeout.
        pulse_start(1); words(1, 50); halt(1, PASS_V, 2'b01); idle(4);

        // Reset asserted during DRAIN discards the run.
        pulse_start(0); words(0, 5); halt(0, PASS_V, 2'b01); idle(2);
        #2;
        rst_n = 1'b0;
        exp_q0.delete();
        #1;
        check_idle(0, "async_reset");
        inst_s[0] = HALT;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        check_idle(0, "no_resume");
        inst_s[0] = NOP;
        pulse_start(0); words(0, 7); halt(0, PASS_V, 2'b01); idle(8);

        // Back-to-back: restart from DONE, then again mid-RUN.
        pulse_start(0); words(0, 10); halt(0, FAIL_V, 2'b10); idle(8);
        pulse_start(0); words(0, 10);
        pulse_start(0); words(0, 3); halt(0, FAIL_V, 2'b10); idle(8);

        for (int i = 0; i < 20 && (exp_q0.size() + exp_q1.size()) != 0; i++) idle(1);
        check("scoreboard_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
